// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit sitting directly after the PC register.
//
// Samples pc, performs one single-beat read on an AR/R instruction bus and hands the
// fetched word to decode over a valid/ready handshake. It also produces next_pc and
// a one-cycle pc_wen pulse that advances the PC register. Only one fetch is ever in
// flight.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc                  current PC register value (sampled in IDLE)
//   pc_wen, next_pc     PC register load strobe and value
//   redirect_valid/_pc  execute-stage control-flow redirect
//   araddr, arvalid, arready            read address channel
//   rdata, rresp, rvalid, rready        read data channel
//   inst_valid, inst_ready              decode handshake
//   inst, inst_pc, inst_fault           fetched word, its pc, access fault flag
module ifu_fetch #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ILEN_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_wen,
    output logic [XLEN-1:0] next_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
);

    typedef enum logic [1:0] {StIdle, StAr, StR, StOut} state_e;

    state_e          state_q, state_d;
    // Set when a redirect overtook a fetch already committed on the bus; the
    // corresponding R beat must be dropped.
    logic            flush_q, flush_d;
    // Shared by araddr and inst_pc: both are the pc sampled in IDLE.
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            fault_q, fault_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            flush_q <= 1'b0;
            addr_q  <= '0;
            inst_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        unique case (state_q)
            StIdle: begin
                // On a redirect the pc port is stale; sample it next cycle instead.
                if (!redirect_valid) begin
                    addr_d = pc;
                    if (pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        inst_d  = '0;
                        state_d = StOut;
                    end else begin
                        state_d = StAr;
                    end
                end
            end
            StAr: begin
                // The address phase cannot be withdrawn; finish it and drop the data.
                if (redirect_valid) flush_d = 1'b1;
                if (arready) state_d = StR;
            end
            StR: begin
                if (rvalid) begin
                    if (flush_q || redirect_valid) begin
                        flush_d = 1'b0;
                        state_d = StIdle;
                    end else begin
                        inst_d  = (rresp == 2'b00) ? rdata : '0;
                        fault_d = (rresp != 2'b00);
                        state_d = StOut;
                    end
                end else if (redirect_valid) begin
                    flush_d = 1'b1;
                end
            end
            StOut: begin
                if (redirect_valid || inst_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        arvalid    = (state_q == StAr);
        rready     = (state_q == StR);
        inst_valid = (state_q == StOut);
        araddr     = addr_q;
        inst_pc    = addr_q;
        inst       = inst_q;
        inst_fault = fault_q;
        // A redirect coinciding with a decode handshake yields one pulse at the target.
        pc_wen     = !rst && (redirect_valid || ((state_q == StOut) && inst_ready));
        next_pc    = redirect_valid ? redirect_pc : addr_q + XLEN'(ILEN_BYTES);
    end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        pc_wen;
    logic [31:0] next_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    ifu_fetch #(.XLEN(32), .ILEN_BYTES(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_wen(pc_wen), .next_pc(next_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_fault(inst_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] next_pc;
        bit          hs;
        logic [31:0] ipc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    // Architectural model: the pc decode should see next
    logic [31:0] model_pc = 32'h0;
    bit          last_wen = 0;
    bit          hs_last = 0;
    int          stall_cnt = 0;

    // Slave model state and timing settings (negative setting = random)
    int          ar_stall_cfg = 0;
    int          r_lat_cfg = 0;
    int          ar_wait = 0;
    int          r_wait = 0;
    bit          r_pend = 0;
    bit          ar_fire = 0;
    bit          r_fire = 0;
    logic [31:0] ar_addr = 32'h0;
    logic [31:0] r_addr = 32'h0;
    int          ar_cnt = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h8000_0413;
    endfunction

    function automatic logic [1:0] mem_resp(input logic [31:0] a);
        return (a[7:2] == 6'h2A) ? 2'd2 : 2'd0;
    endfunction

    function automatic logic exp_fault(input logic [31:0] p);
        return (p[1:0] != 2'b00) || (mem_resp(p) != 2'd0);
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] p);
        return exp_fault(p) ? 32'h0 : mem_data(p);
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [1:0] lo;
        lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return {16'h8000, 14'($urandom), lo};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic slave_step();
        if (rst) begin
            ar_fire = 0; r_fire = 0; r_pend = 0; rvalid = 1'b0; arready = 1'b0; ar_wait = 0;
            return;
        end
        if (r_fire) begin
            r_pend = 0;
            rvalid = 1'b0;
        end
        if (ar_fire) begin
            r_pend = 1;
            r_addr = ar_addr;
            r_wait = (r_lat_cfg < 0) ? int'($urandom_range(0, 3)) : r_lat_cfg;
        end
        if (r_pend && !rvalid) begin
            if (r_wait == 0) begin
                rvalid = 1'b1;
                rdata  = mem_data(r_addr);
                rresp  = mem_resp(r_addr);
            end else begin
                r_wait--;
            end
        end
        if (arvalid) begin
            arready = (ar_stall_cfg < 0) ? ($urandom_range(0, 2) == 0) : (ar_wait >= ar_stall_cfg);
            ar_wait++;
        end else begin
            arready = 1'b0;
            ar_wait = 0;
        end
        ar_fire = arvalid && arready;
        ar_addr = araddr;
        if (ar_fire) begin
            ar_cnt++;
            ar_wait = 0;
        end
        r_fire = rvalid && rready;
    endtask

    // One clock of stimulus: applied at the falling edge, expectations pushed alongside.
    task automatic cycle(input bit r, input bit redir, input logic [31:0] rpc, input bit rdy);
        exp_t e;
        @(negedge clk);
        rst = r;
        slave_step();
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        hs_last = 0;
        if (r) begin
            exp_q.delete();
            last_wen = 0;
            stall_cnt = 0;
        end else begin
            redirect_valid = redir && !last_wen;
            redirect_pc = rpc;
            inst_ready = rdy;
            hs_last = inst_valid && rdy;
            e.hs = 0; e.ipc = 32'h0; e.inst = 32'h0; e.fault = 1'b0;
            if (redirect_valid) begin
                e.next_pc = rpc;
                exp_q.push_back(e);
                model_pc = rpc;
                hs_last = 0;
            end else if (hs_last) begin
                e.next_pc = model_pc + 32'd4;
                e.hs = 1;
                e.ipc = model_pc;
                e.inst = exp_inst(model_pc);
                e.fault = exp_fault(model_pc);
                exp_q.push_back(e);
                model_pc = model_pc + 32'd4;
            end
            last_wen = redirect_valid || hs_last;
            stall_cnt = last_wen ? 0 : stall_cnt + 1;
        end
        pc = model_pc;
    endtask

    // Reset into a new pc and check the outputs in the first cycle after reset.
    task automatic reset_to(input logic [31:0] npc);
        model_pc = npc;
        cycle(1, 0, 32'h0, 0);
        cycle(0, 0, 32'h0, 0);
        chk("rst_arvalid", 32'(arvalid), 32'h0);
        chk("rst_rready", 32'(rready), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_fault", 32'(inst_fault), 32'h0);
        chk("rst_araddr", araddr, 32'h0);
    endtask

    task automatic run_until_hs(input int limit);
        int n = 0;
        do begin
            cycle(0, 0, 32'h0, 1);
            n++;
        end while (!hs_last && n < limit);
        if (!hs_last) chk("hs_timeout", 32'(n), 32'(limit + 1));
    endtask

    // which: 0 arvalid, 1 rready, 2 inst_valid
    task automatic wait_sig(input int which, input int limit);
        int  n = 0;
        bit  s;
        s = 0;
        while (!s && n < limit) begin
            cycle(0, 0, 32'h0, 0);
            n++;
            s = (which == 0) ? arvalid : (which == 1) ? rready : inst_valid;
        end
        if (!s) chk("wait_timeout", 32'(which), 32'hFFFF_FFFF);
    endtask

    // Monitor: compares pc_wen/next_pc and the handed-off instruction against the queue.
    exp_t        mon_e;
    bit          prev_ar_stall = 0;
    logic [31:0] prev_araddr = 32'h0;

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            chk("pc_wen", 32'(pc_wen), 32'(exp_q.size() != 0));
            if (pc_wen && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("next_pc", next_pc, mon_e.next_pc);
                if (mon_e.hs) begin
                    chk("inst_pc", inst_pc, mon_e.ipc);
                    chk("inst", inst, mon_e.inst);
                    chk("inst_fault", 32'(inst_fault), 32'(mon_e.fault));
                end
            end
            exp_q.delete();
            if (prev_ar_stall) begin
                chk("arvalid_hold", 32'(arvalid), 32'h1);
                chk("araddr_hold", araddr, prev_araddr);
            end
            prev_ar_stall = arvalid && !arready;
            prev_araddr = araddr;
        end else begin
            prev_ar_stall = 0;
        end
    end

    initial begin
        int ar0;
        int iv_cnt;

        // Zero-wait fetch: AR on cycle 1, instruction on cycle 3.
        ar_stall_cfg = 0; r_lat_cfg = 0;
        reset_to(32'h8000_0000);
        chk("c0_arvalid", 32'(arvalid), 32'h0);
        cycle(0, 0, 32'h0, 0);
        chk("c1_arvalid", 32'(arvalid), 32'h1);
        chk("c1_araddr", araddr, 32'h8000_0000);
        cycle(0, 0, 32'h0, 0);
        chk("c2_rready", 32'(rready), 32'h1);
        chk("c2_inst_valid", 32'(inst_valid), 32'h0);
        cycle(0, 0, 32'h0, 1);
        chk("c3_inst_valid", 32'(inst_valid), 32'h1);
        chk("c3_inst", inst, 32'h0000_0413);
        chk("c3_inst_pc", inst_pc, 32'h8000_0000);

        // Slow slave: 5 stalled AR cycles, 3-cycle read latency, a single AR handshake.
        ar_stall_cfg = 5; r_lat_cfg = 3;
        reset_to(32'h8000_0010);
        ar0 = ar_cnt;
        run_until_hs(40);
        chk("ar_count", 32'(ar_cnt - ar0), 32'h1);

        // Redirect while in R: late data is dropped, refetch from the target.
        ar_stall_cfg = 0; r_lat_cfg = 3;
        reset_to(32'h8000_0020);
        wait_sig(1, 20);
        cycle(0, 1, 32'h8000_0100, 0);
        iv_cnt = 0;
        for (int n = 0; n < 20 && !arvalid; n++) begin
            cycle(0, 0, 32'h0, 0);
            if (inst_valid) iv_cnt++;
        end
        chk("flush_no_inst", 32'(iv_cnt), 32'h0);
        chk("redir_araddr", araddr, 32'h8000_0100);
        run_until_hs(20);

        // Decode back-pressure, then ready and redirect together.
        r_lat_cfg = 0;
        reset_to(32'h8000_0040);
        wait_sig(2, 20);
        for (int n = 0; n < 4; n++) begin
            cycle(0, 0, 32'h0, 0);
            chk("hold_valid", 32'(inst_valid), 32'h1);
            chk("hold_inst", inst, mem_data(32'h8000_0040));
            chk("hold_inst_pc", inst_pc, 32'h8000_0040);
        end
        cycle(0, 1, 32'h8000_0200, 1);
        run_until_hs(20);

        // pc wrap, misaligned pc, bus error
        reset_to(32'hFFFF_FFFC);
        run_until_hs(20);
        reset_to(32'h8000_0002);
        cycle(0, 0, 32'h0, 0);
        chk("mis_arvalid", 32'(arvalid), 32'h0);
        chk("mis_inst_valid", 32'(inst_valid), 32'h1);
        chk("mis_fault", 32'(inst_fault), 32'h1);
        chk("mis_inst", inst, 32'h0);
        run_until_hs(5);
        reset_to(32'h8000_00A8);
        run_until_hs(20);

        // Reset in the middle of a read, then restart from a new pc.
        r_lat_cfg = 3;
        reset_to(32'h8000_0050);
        wait_sig(1, 20);
        reset_to(32'h8000_0300);
        run_until_hs(20);

        // Randomised traffic
        ar_stall_cfg = -1; r_lat_cfg = -1;
        for (int i = 0; i < 4000; i++) begin
            if (stall_cnt > 60) begin
                chk("progress", 32'(stall_cnt), 32'h0);
                reset_to(rand_pc());
            end else if ($urandom_range(0, 299) == 0) begin
                reset_to(rand_pc());
            end else begin
                cycle(0, $urandom_range(0, 15) == 0, rand_pc(), $urandom_range(0, 1) == 1);
            end
        end

        @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
